// File: rtl/tsn_tb_pkg.sv
// Shared types and constants for the AXIS packet checker: FSM states, err_flags bit map,
// expected header layout and a saturating counter helper.
package tsn_tb_pkg;

  typedef enum logic [1:0] {
    S_HEAD   = 2'd0,
    S_BODY   = 2'd1,
    S_REPORT = 2'd2
  } chk_state_t;

  localparam int ERR_DST     = 0;
  localparam int ERR_SRC     = 1;
  localparam int ERR_TAG     = 2;
  localparam int ERR_TUSER   = 3;
  localparam int ERR_PAYLOAD = 4;
  localparam int ERR_LENGTH  = 5;
  localparam int ERR_KEEP    = 6;
  localparam int ERR_W       = 7;

  localparam int VLAN_HDR_LEN      = 16;
  localparam int ETH_HDR_LEN       = 14;
  localparam int MAX_PACKET_LENGTH = 1542;

  // Byte 0 of the frame is the MSB of this struct.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] tag;
  } hdr_t;

  function automatic hdr_t make_exp_hdr(input logic [47:0] dst, input logic [47:0] src,
                                        input logic vlan, input logic [15:0] etype,
                                        input logic [2:0] pri);
    hdr_t h;
    h.dst_mac = dst;
    h.src_mac = src;
    h.tag     = vlan ? {8'h81, 8'h00, pri, 5'b0, 8'h00} : {etype, 16'h0000};
    return h;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational popcount of an AXIS tkeep mask; zero latency, no flow control.
module axis_keep_popcount #(
  parameter int LANES = 32,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] keep,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/axis_packet_checker.sv
// AXIS frame checker: header, payload pattern (PKT_CHECKER_PAYLOAD_CHECK_EN), length, keep, tuser source.
// Report pulse the cycle after the tlast handshake; tready follows rotating READY_PATTERN, low in report cycle.
module axis_packet_checker
  import tsn_tb_pkg::*;
#(
  parameter int          AXIS_DATA_WIDTH  = 256,
  parameter int          AXIS_TUSER_WIDTH = 128,
  parameter logic [47:0] EXP_DST_MAC      = 48'h1111_1111_1111,
  parameter logic [47:0] EXP_SRC_MAC      = 48'h2222_2222_2222,
  parameter logic        VLAN             = 1'b1,
  parameter logic [15:0] TYPE             = 16'h0800,
  parameter logic [2:0]  PRI              = 3'b111,
  parameter logic [7:0]  EXP_TUSER_SRC    = 8'h01,
  parameter int          EXP_LENGTH       = 1500,
  parameter logic [31:0] READY_PATTERN    = 32'hFFFF_FFFF
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          pkt_done,
  output logic                          pkt_ok,
  output logic [ERR_W-1:0]              err_flags,
  output logic [31:0]                   pkt_count,
  output logic [31:0]                   err_count
);

  localparam int          LANES     = AXIS_DATA_WIDTH / 8;
  localparam int          CW        = $clog2(LANES + 1);
  localparam int          HDR_LEN   = VLAN ? VLAN_HDR_LEN : ETH_HDR_LEN;
  localparam hdr_t        EXP_HDR   = make_exp_hdr(EXP_DST_MAC, EXP_SRC_MAC, VLAN, TYPE, PRI);
  localparam logic [15:0] EXP_LEN16 = 16'(EXP_LENGTH);

  generate
    if (AXIS_DATA_WIDTH < 128 || AXIS_TUSER_WIDTH < 25) begin : g_param_check
      $error("axis_packet_checker: AXIS_DATA_WIDTH must be >= 128 and AXIS_TUSER_WIDTH >= 25");
    end
  endgenerate

  chk_state_t       state_q, state_d;
  logic [31:0]      pattern_q;
  logic [ERR_W-1:0] err_q, err_d, beat_err;
  logic [15:0]      len_q, len_d;
  logic [16:0]      len_sum;
  logic [CW-1:0]    keep_cnt;
  logic [2:0]       hdr_err;
  logic             pay_err;
  logic             beat_acc;
  logic             unused_bits;

  assign unused_bits = ^{s_axis_tuser[AXIS_TUSER_WIDTH-1:24], s_axis_tuser[15:0], s_axis_tdata};

  assign s_axis_tready = axis_resetn && pattern_q[0] && (state_q != S_REPORT);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  axis_keep_popcount #(.LANES(LANES), .CW(CW)) u_keep_popcount (
    .keep  (s_axis_tkeep),
    .count (keep_cnt)
  );

  assign len_sum = {1'b0, len_q} + 17'(keep_cnt);
  assign len_d   = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  // The whole header sits in the first beat, so header lanes are only compared in S_HEAD.
  always_comb begin
    hdr_err = '0;
    if (state_q == S_HEAD) begin
      for (int j = 0; j < VLAN_HDR_LEN; j++) begin
        if (j < HDR_LEN && s_axis_tkeep[j] &&
            s_axis_tdata[8*j +: 8] != EXP_HDR[8*(15-j) +: 8]) begin
          if (j < 6)       hdr_err[0] = 1'b1;
          else if (j < 12) hdr_err[1] = 1'b1;
          else             hdr_err[2] = 1'b1;
        end
      end
    end
  end

`ifdef PKT_CHECKER_PAYLOAD_CHECK_EN
  // Only the low byte of the running offset matters for the o[7:0] pattern.
  logic [7:0] base_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn)              base_q <= '0;
    else if (state_q == S_REPORT)  base_q <= '0;
    else if (beat_acc)             base_q <= base_q + 8'(LANES);
  end

  always_comb begin
    pay_err = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (s_axis_tkeep[j] && !(state_q == S_HEAD && j < HDR_LEN) &&
          s_axis_tdata[8*j +: 8] != (base_q + 8'(j))) begin
        pay_err = 1'b1;
      end
    end
  end
`else
  assign pay_err = 1'b0;
`endif

  always_comb begin
    beat_err              = '0;
    beat_err[ERR_DST]     = hdr_err[0];
    beat_err[ERR_SRC]     = hdr_err[1];
    beat_err[ERR_TAG]     = hdr_err[2];
    beat_err[ERR_TUSER]   = (s_axis_tuser[23:16] != EXP_TUSER_SRC);
    beat_err[ERR_PAYLOAD] = pay_err;
    beat_err[ERR_LENGTH]  = s_axis_tlast && (len_d != EXP_LEN16);
    beat_err[ERR_KEEP]    = !s_axis_tlast && (s_axis_tkeep != '1);
  end

  assign err_d = err_q | beat_err;

  always_comb begin
    state_d  = state_q;
    pkt_done = 1'b0;
    pkt_ok   = 1'b0;
    unique case (state_q)
      S_HEAD:   if (beat_acc) state_d = s_axis_tlast ? S_REPORT : S_BODY;
      S_BODY:   if (beat_acc && s_axis_tlast) state_d = S_REPORT;
      S_REPORT: begin
        pkt_done = 1'b1;
        pkt_ok   = (err_q == '0);
        state_d  = S_HEAD;
      end
      default:  state_d = S_HEAD;
    endcase
  end

  assign err_flags = err_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= S_HEAD;
      pattern_q <= READY_PATTERN;
      err_q     <= '0;
      len_q     <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= {pattern_q[0], pattern_q[31:1]};
      if (state_q == S_REPORT) begin
        err_q <= '0;
        len_q <= '0;
      end else if (beat_acc) begin
        err_q <= err_d;
        len_q <= len_d;
      end
      // Counters land with the tlast handshake so they are current while pkt_done is high.
      if (beat_acc && s_axis_tlast) begin
        pkt_count <= sat_inc32(pkt_count);
        if (err_d != '0) err_count <= sat_inc32(err_count);
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_checker.sv
// Scoreboard bench for axis_packet_checker: directed and random frames against a byte-level frame model.
module tb_axis_packet_checker;
  import tsn_tb_pkg::*;

  localparam int          DW      = 256;
  localparam int          LANES   = DW / 8;
  localparam int          UW      = 128;
  localparam int          EXP_LEN = 1500;
  localparam logic [7:0]  EXP_SRC = 8'h01;
  localparam logic [31:0] TB_PAT  = 32'hFFFF_5555;

  logic             axis_aclk;
  logic             axis_resetn;
  logic [DW-1:0]    s_axis_tdata;
  logic [LANES-1:0] s_axis_tkeep;
  logic [UW-1:0]    s_axis_tuser;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic             pkt_done;
  logic             pkt_ok;
  logic [6:0]       err_flags;
  logic [31:0]      pkt_count;
  logic [31:0]      err_count;

  axis_packet_checker #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_TUSER_WIDTH(UW),
    .READY_PATTERN   (TB_PAT)
  ) dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .pkt_done      (pkt_done),
    .pkt_ok        (pkt_ok),
    .err_flags     (err_flags),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  typedef struct packed {
    logic [6:0]  flags;
    logic [31:0] pc;
    logic [31:0] ec;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [DW-1:0]    f_dat[$];
  logic [LANES-1:0] f_keep[$];
  logic [7:0]       f_usr[$];
  logic [31:0]      pc, ec;
  logic [31:0]      pat_v = TB_PAT;
  logic [4:0]       rot;
  int               total, bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame byte at offset o as emitted by the generator (VLAN-tagged header).
  function automatic logic [7:0] exp_byte(input int o);
    if (o < 6)   return 8'h11;
    if (o < 12)  return 8'h22;
    if (o == 12) return 8'h81;
    if (o == 14) return 8'hE0;
    if (o < 16)  return 8'h00;
    return o[7:0];
  endfunction

  task automatic build_frame(input int n, input bit hi_align);
    int nb, r;
    logic [DW-1:0]    d;
    logic [LANES:0]   lo;
    logic [LANES-1:0] k;
    f_dat.delete(); f_keep.delete(); f_usr.delete();
    nb = (n + LANES - 1) / LANES;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < LANES; j++) d[8*j +: 8] = exp_byte(b * LANES + j);
      if (b < nb - 1) k = '1;
      else begin
        r  = n - LANES * (nb - 1);
        lo = (33'd1 << r) - 33'd1;
        k  = hi_align ? ({LANES{1'b1}} << (LANES - r)) : lo[LANES-1:0];
      end
      f_dat.push_back(d); f_keep.push_back(k); f_usr.push_back(EXP_SRC);
    end
  endtask

  task automatic set_byte(input int b, input int j, input logic [7:0] v);
    logic [DW-1:0] t;
    t = f_dat[b];
    t[8*j +: 8] = v;
    f_dat[b] = t;
  endtask

  function automatic logic [7:0] get_byte(input int b, input int j);
    logic [DW-1:0] t;
    t = f_dat[b];
    return t[8*j +: 8];
  endfunction

  function automatic logic [6:0] model_flags();
    logic [6:0] f;
    int len;
    f = '0;
    len = 0;
    for (int b = 0; b < f_dat.size(); b++) begin
      len += $countones(f_keep[b]);
      if (f_usr[b] != EXP_SRC) f[ERR_TUSER] = 1'b1;
      if (b != f_dat.size() - 1 && f_keep[b] != '1) f[ERR_KEEP] = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        int o;
        o = b * LANES + j;
        if (f_keep[b][j] && get_byte(b, j) != exp_byte(o)) begin
          if (o < 6)       f[ERR_DST] = 1'b1;
          else if (o < 12) f[ERR_SRC] = 1'b1;
          else if (o < 16) f[ERR_TAG] = 1'b1;
          else begin
`ifdef PKT_CHECKER_PAYLOAD_CHECK_EN
            f[ERR_PAYLOAD] = 1'b1;
`endif
          end
        end
      end
    end
    if (len != EXP_LEN) f[ERR_LENGTH] = 1'b1;
    return f;
  endfunction

  task automatic finish_now(input string why);
    $display("FAIL %s: bound expired", why);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [LANES-1:0] k,
                            input logic [7:0] usr, input bit last);
    bit acc;
    int waited;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {8{$urandom}};
        s_axis_tlast  = 1'($urandom_range(0, 1));
        @(posedge axis_aclk); #1;
      end
    end
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = {{(UW-24){1'b0}} | UW'({$urandom, $urandom}) , usr, 16'($urandom)};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc) begin
      @(negedge axis_aclk);
      acc = s_axis_tready;
      @(posedge axis_aclk); #1;
      waited++;
      if (waited > 200) finish_now("handshake_timeout");
    end
  endtask

  task automatic send_frame();
    exp_t e;
    logic [6:0] f;
    f = model_flags();
    pc = pc + 32'd1;
    if (f != '0) ec = ec + 32'd1;
    e.flags = f; e.pc = pc; e.ec = ec;
    sb.push_back(e);
    for (int b = 0; b < f_dat.size(); b++)
      drive_beat(f_dat[b], f_keep[b], f_usr[b], b == f_dat.size() - 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 5000) begin
      @(posedge axis_aclk);
      c++;
    end
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge axis_aclk);
    check({tag, "_tready"},    s_axis_tready, 1'b0);
    check({tag, "_pkt_done"},  pkt_done, 1'b0);
    check({tag, "_pkt_ok"},    pkt_ok, 1'b0);
    check({tag, "_err_flags"}, err_flags, 7'd0);
    check({tag, "_pkt_count"}, pkt_count, 32'd0);
    check({tag, "_err_count"}, err_count, 32'd0);
  endtask

  always @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) rot <= '0;
    else              rot <= rot + 5'd1;
  end

  always @(negedge axis_aclk) begin
    if (axis_resetn) begin
      if (pkt_done) begin
        check("tready_in_report", s_axis_tready, 1'b0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pkt_done: got a report, required none pending");
        end else begin
          mon_e = sb.pop_front();
          check("err_flags", err_flags, mon_e.flags);
          check("pkt_ok",    pkt_ok, mon_e.flags == 7'd0);
          check("pkt_count", pkt_count, mon_e.pc);
          check("err_count", err_count, mon_e.ec);
        end
      end else begin
        check("tready_pattern", s_axis_tready, pat_v[rot]);
      end
    end
  end

  initial begin
    #2_000_000;
    finish_now("watchdog");
  end

  initial begin
    int kind, n, b, j, nb;
    total = 0; bad = 0; pc = '0; ec = '0;
    axis_resetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tuser = '0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge axis_aclk);
    check_reset_state("reset");
    @(posedge axis_aclk); #1;
    axis_resetn = 1'b1;

    // Three nominal 1500 B frames, last beat keep 32'hFFFF_FFF0.
    repeat (3) begin
      build_frame(EXP_LEN, 1'b1);
      send_frame();
    end
    // Source MAC byte 7 zeroed.
    build_frame(EXP_LEN, 1'b1); set_byte(0, 7, 8'h00); send_frame();
    // Truncated frame ending on a full beat.
    build_frame(1472, 1'b0); send_frame();
    // Payload byte 200 flipped.
    build_frame(EXP_LEN, 1'b0); set_byte(200 / LANES, 200 % LANES, ~get_byte(200 / LANES, 200 % LANES)); send_frame();

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      n = (kind == 2) ? $urandom_range(1, 1600) : EXP_LEN;
      build_frame(n, 1'($urandom_range(0, 1)));
      nb = f_dat.size();
      if (kind == 1 || kind == 5) begin
        b = $urandom_range(0, nb - 1);
        j = $urandom_range(0, LANES - 1);
        set_byte(b, j, get_byte(b, j) ^ 8'($urandom_range(1, 255)));
      end
      if (kind == 3 || kind == 5) f_usr[$urandom_range(0, nb - 1)] = 8'($urandom_range(2, 255));
      if (kind == 4 && nb > 1) begin
        b = $urandom_range(0, nb - 2);
        f_keep[b] = f_keep[b] & ~(LANES'(1) << $urandom_range(0, LANES - 1));
      end
      send_frame();
    end
    wait_drain();

    // Reset in the middle of a frame: partial frame is dropped, counters clear.
    build_frame(EXP_LEN, 1'b1);
    for (int k = 0; k < 10; k++) drive_beat(f_dat[k], f_keep[k], f_usr[k], 1'b0);
    axis_resetn = 1'b0;
    s_axis_tvalid = 1'b0;
    pc = '0; ec = '0;
    check_reset_state("midframe_reset");
    repeat (2) @(posedge axis_aclk);
    #1 axis_resetn = 1'b1;
    build_frame(EXP_LEN, 1'b1);
    send_frame();
    wait_drain();

    repeat (5) @(posedge axis_aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
